axis_frame_arbiter: RTL and testbench
=====================================

# axis_frame_arbiter

Frame-aware round-robin arbiter that merges S_COUNT AXI-Stream sources into one stream feeding a shared frame FIFO. Once a source is granted, the grant is held until that source's tlast beat is accepted, so frames are never interleaved. A single registered output stage decouples the arbiter from the FIFO's s_axis_tready.

## Interface
- S_COUNT, 4, number of input sources (2..16)
- DATA_WIDTH, 8, tdata width per source
- KEEP_ENABLE, DATA_WIDTH>8, carry tkeep
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- LAST_ENABLE, 1, when 0 every beat is treated as a complete frame
- ID_WIDTH, 8; DEST_WIDTH, 8; USER_WIDTH, 1, sideband widths, always carried
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  packed, source i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  packed
- s_axis_tvalid  in  S_COUNT  per-source valid
- s_axis_tready  out  S_COUNT  per-source ready
- s_axis_tlast  in  S_COUNT; s_axis_tid / tdest / tuser  in  S_COUNT*ID_WIDTH / DEST_WIDTH / USER_WIDTH  packed
- m_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser  out  single-stream widths  merged output
- m_axis_tready  in  1  downstream ready
- grant_valid  out  1  a frame is in progress
- grant_index  out  $clog2(S_COUNT)  source currently granted

## Operation
- States: IDLE, XFER. Reset: IDLE, grant_valid=0, grant_index=0, last-grant pointer=S_COUNT-1, m_axis_tvalid=0, all s_axis_tready=0.
- IDLE: if any s_axis_tvalid, select first asserted source searching from (last_grant+1) mod S_COUNT upward with wrap; register grant_index, last_grant := selection, go XFER. No beat transferred in IDLE.
- XFER: s_axis_tready[i] = (i==grant_index) && (!m_axis_tvalid || m_axis_tready); all other readies 0. An accepted beat is loaded into the output register.
- Accepted beat with tlast=1 (or any beat when LAST_ENABLE=0): return to IDLE next cycle.
- Granted source deasserting tvalid mid-frame: grant held, no switch (wait indefinitely).
- Output register: m_axis_tvalid set on input accept; cleared when m_axis_tready && no new accept same cycle. Load and drain in same cycle permitted (full throughput within a frame).
- Sideband fields pass unchanged; tkeep output tied all-ones when KEEP_ENABLE=0.
- Reset mid-frame: all state to reset values next cycle; partial beat in output register discarded.

## Timing
- Arbitration latency: 1 cycle (IDLE) from tvalid to s_axis_tready.
- Input-to-output latency: 1 cycle (registered).
- Inter-frame gap: exactly one IDLE cycle after each tlast acceptance; peak throughput for frames of L beats is L/(L+1).
- Within a frame, 1 beat/cycle while m_axis_tready=1.
- s_axis_tready depends combinationally on m_axis_tready (no skid buffer).

## Structure
- Shared package axis_pkg: state enum (IDLE, XFER), clog2 helper, packed-slice index helpers.
- One sub-module natural: arb_rr_select — combinational round-robin priority select (request vector, last-grant pointer -> index, valid); parameter S_COUNT.

## Test plan
- Single source: source 2 sends 3-beat frame 0xA1,0xA2,0xA3(last), m_axis_tready=1 -> grant_index=2 one cycle after tvalid; output beats appear 1 cycle after each accept; return to IDLE.
- Fairness: all 4 sources hold 2-beat frames continuously from reset -> grant order 0,1,2,3,0, one idle cycle between frames, no interleaving.
- Backpressure: source 1 5-beat frame, m_axis_tready toggles 1,0,0,1,... -> no beat lost or duplicated, s_axis_tready[1] tracks m_axis_tready while output full.
- Mid-frame stall: granted source 0 drops tvalid for 3 cycles while source 3 valid -> grant stays 0 until its tlast, then source 3 granted.
- LAST_ENABLE=0: sources 0 and 1 both valid -> beats alternate 0,1,0,1 with idle cycles between.
- Reset during XFER beat 2 of 4 -> next cycle m_axis_tvalid=0, grant_valid=0, s_axis_tready=0; next arbitration starts at source 0.

Source files
------------

// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared types and helpers for the frame arbiter
package axis_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A single source still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/axis_frame_arbiter_if.sv
// rtl/axis_frame_arbiter_if.sv - packed multi-lane stream bundle with master/slave views
interface axis_frame_arbiter_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [N*DATA_WIDTH-1:0] tdata;
    logic [N*KEEP_WIDTH-1:0] tkeep;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tready;
    logic [N-1:0]            tlast;
    logic [N*ID_WIDTH-1:0]   tid;
    logic [N*DEST_WIDTH-1:0] tdest;
    logic [N*USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/arb_rr_select.sv
// rtl/arb_rr_select.sv - combinational round-robin pick starting after the last grant
module arb_rr_select
    import axis_pkg::*;
#(
    parameter int  S_COUNT = 4,
    localparam int IDX_W   = idx_width(S_COUNT)
) (
    input  logic [S_COUNT-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_index,
    output logic               o_valid
);

    logic [IDX_W-1:0] w_pos;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        w_pos   = '0;
        for (int k = S_COUNT; k >= 1; k--) begin
            w_pos = IDX_W'((int'(i_last) + k) % S_COUNT);
            if (i_req[w_pos]) begin
                o_valid = 1'b1;
                o_index = w_pos;
            end
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-atomic round-robin merge of S_COUNT streams into one registered output
module axis_frame_arbiter
    import axis_pkg::*;
#(
    parameter int  S_COUNT     = 4,
    parameter int  DATA_WIDTH  = 8,
    parameter bit  KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int  KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter bit  LAST_ENABLE = 1'b1,
    parameter int  ID_WIDTH    = 8,
    parameter int  DEST_WIDTH  = 8,
    parameter int  USER_WIDTH  = 1,
    localparam int IDX_W       = idx_width(S_COUNT)
) (
    input  logic               clk,
    input  logic               rst,
    axis_frame_arbiter_if.slave  s_axis,
    axis_frame_arbiter_if.master m_axis,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_index
);

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic [IDX_W-1:0]       r_grant_index;
    logic [IDX_W-1:0]       r_last_grant;
    logic [IDX_W-1:0]       w_sel_index;
    logic                   w_sel_valid;
    logic                   w_out_ready;
    logic                   w_accept;
    logic                   w_beat_last;
    logic [S_COUNT-1:0]     w_tready;

    logic                   w_cur_valid;
    logic                   w_cur_last;
    logic [DATA_WIDTH-1:0]  w_cur_tdata;
    logic [KEEP_WIDTH-1:0]  w_cur_tkeep;
    logic [ID_WIDTH-1:0]    w_cur_tid;
    logic [DEST_WIDTH-1:0]  w_cur_tdest;
    logic [USER_WIDTH-1:0]  w_cur_tuser;

    logic                   r_m_tvalid;
    logic                   r_m_tlast;
    logic [DATA_WIDTH-1:0]  r_m_tdata;
    logic [KEEP_WIDTH-1:0]  r_m_tkeep;
    logic [ID_WIDTH-1:0]    r_m_tid;
    logic [DEST_WIDTH-1:0]  r_m_tdest;
    logic [USER_WIDTH-1:0]  r_m_tuser;

    arb_rr_select #(.S_COUNT(S_COUNT)) u_select (
        .i_req   (s_axis.tvalid),
        .i_last  (r_last_grant),
        .o_index (w_sel_index),
        .o_valid (w_sel_valid)
    );

    // Lane mux for the granted source.
    always_comb begin
        w_cur_valid = 1'b0;
        w_cur_last  = 1'b0;
        w_cur_tdata = '0;
        w_cur_tkeep = '0;
        w_cur_tid   = '0;
        w_cur_tdest = '0;
        w_cur_tuser = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (r_grant_index == IDX_W'(i)) begin
                w_cur_valid = s_axis.tvalid[i];
                w_cur_last  = s_axis.tlast[i];
                w_cur_tdata = s_axis.tdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
                w_cur_tkeep = s_axis.tkeep[slice_lo(i, KEEP_WIDTH) +: KEEP_WIDTH];
                w_cur_tid   = s_axis.tid[slice_lo(i, ID_WIDTH) +: ID_WIDTH];
                w_cur_tdest = s_axis.tdest[slice_lo(i, DEST_WIDTH) +: DEST_WIDTH];
                w_cur_tuser = s_axis.tuser[slice_lo(i, USER_WIDTH) +: USER_WIDTH];
            end
        end
    end

    assign w_out_ready = !r_m_tvalid || m_axis.tready[0];
    assign w_accept    = (r_state == ST_XFER) && w_cur_valid && w_out_ready;
    assign w_beat_last = LAST_ENABLE ? w_cur_last : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant_index <= '0;
            r_last_grant  <= IDX_W'(S_COUNT - 1);
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_sel_valid) begin
                r_grant_index <= w_sel_index;
                r_last_grant  <= w_sel_index;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_sel_valid) w_state_next = ST_XFER;
            ST_XFER: if (w_accept && w_beat_last) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tready    = '0;
        grant_valid = (r_state == ST_XFER);
        if (r_state == ST_XFER) w_tready[r_grant_index] = w_out_ready;
    end

    // Single output stage: load on accept, otherwise drain when downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tid    <= '0;
            r_m_tdest  <= '0;
            r_m_tuser  <= '0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= w_beat_last;
            r_m_tdata  <= w_cur_tdata;
            r_m_tkeep  <= w_cur_tkeep;
            r_m_tid    <= w_cur_tid;
            r_m_tdest  <= w_cur_tdest;
            r_m_tuser  <= w_cur_tuser;
        end else if (m_axis.tready[0]) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign s_axis.tready = w_tready;
    assign grant_index   = r_grant_index;
    assign m_axis.tvalid = r_m_tvalid;
    assign m_axis.tlast  = r_m_tlast;
    assign m_axis.tdata  = r_m_tdata;
    assign m_axis.tkeep  = KEEP_ENABLE ? r_m_tkeep : {KEEP_WIDTH{1'b1}};
    assign m_axis.tid    = r_m_tid;
    assign m_axis.tdest  = r_m_tdest;
    assign m_axis.tuser  = r_m_tuser;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb/tb_axis_frame_arbiter.sv - directed self-checking bench for axis_frame_arbiter
module tb_axis_frame_arbiter;

    localparam int S  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_frame_arbiter_if #(.N(S), .DATA_WIDTH(DW), .KEEP_WIDTH(1)) s_if ();
    axis_frame_arbiter_if #(.N(1), .DATA_WIDTH(DW), .KEEP_WIDTH(1)) m_if ();
    axis_frame_arbiter_if #(.N(S), .DATA_WIDTH(DW), .KEEP_WIDTH(1)) s2_if ();
    axis_frame_arbiter_if #(.N(1), .DATA_WIDTH(DW), .KEEP_WIDTH(1)) m2_if ();

    logic       gv, gv2;
    logic [1:0] gi, gi2;

    axis_frame_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .LAST_ENABLE(1'b1)) dut (
        .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
        .grant_valid(gv), .grant_index(gi)
    );

    axis_frame_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .LAST_ENABLE(1'b0)) dut_nl (
        .clk(clk), .rst(rst), .s_axis(s2_if), .m_axis(m2_if),
        .grant_valid(gv2), .grant_index(gi2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Source model: frames of src_len beats, data = base + beat index.
    int         src_frames [S];
    int         src_len    [S];
    int         src_beat   [S];
    logic [7:0] src_base   [S];
    logic [S-1:0] src_stall;
    logic [S-1:0] fire_q;
    logic m_rdy;
    logic en2;

    always_comb begin
        s_if.tvalid = '0;
        s_if.tdata  = '0;
        s_if.tkeep  = '1;
        s_if.tlast  = '0;
        s_if.tid    = '0;
        s_if.tdest  = '0;
        s_if.tuser  = '0;
        for (int i = 0; i < S; i++) begin
            s_if.tvalid[i]         = (src_frames[i] > 0) && !src_stall[i];
            s_if.tdata[i*8 +: 8]   = src_base[i] + 8'(src_beat[i]);
            s_if.tlast[i]          = (src_beat[i] == src_len[i] - 1);
            s_if.tid[i*8 +: 8]     = 8'(i);
            s_if.tdest[i*8 +: 8]   = 8'h10 + 8'(i);
            s_if.tuser[i]          = (src_beat[i] % 2 == 1);
        end
    end

    assign m_if.tready  = m_rdy;
    assign s2_if.tvalid = en2 ? 4'b0011 : 4'b0000;
    assign s2_if.tdata  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    assign s2_if.tkeep  = '1;
    assign s2_if.tlast  = '0;
    assign s2_if.tid    = {8'd3, 8'd2, 8'd1, 8'd0};
    assign s2_if.tdest  = '0;
    assign s2_if.tuser  = '0;
    assign m2_if.tready = 1'b1;

    typedef struct {
        logic [7:0] data;
        logic [7:0] id;
        logic [7:0] dest;
        logic       last;
        int         stamp;
    } beat_t;

    beat_t out_q[$];
    beat_t out2_q[$];
    int    grant_q[$];
    int    cyc = 0;
    logic  gv_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        fire_q = s_if.tvalid & s_if.tready;
        if (!rst && m_if.tvalid[0] && m_if.tready[0])
            out_q.push_back('{data: m_if.tdata, id: m_if.tid, dest: m_if.tdest, last: m_if.tlast[0], stamp: cyc});
        if (!rst && m2_if.tvalid[0] && m2_if.tready[0])
            out2_q.push_back('{data: m2_if.tdata, id: m2_if.tid, dest: m2_if.tdest, last: m2_if.tlast[0], stamp: cyc});
        if (!rst && gv && !gv_prev) grant_q.push_back(int'(gi));
        gv_prev = rst ? 1'b0 : gv;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < S; i++) begin
                if (fire_q[i]) begin
                    src_beat[i]++;
                    if (src_beat[i] == src_len[i]) begin
                        src_beat[i] = 0;
                        src_frames[i]--;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < S; i++) begin
            src_frames[i] = 0;
            src_len[i]    = 1;
            src_beat[i]   = 0;
            src_base[i]   = 8'h00;
        end
        src_stall = '0;
        m_rdy     = 1'b1;
        en2       = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    int ob, og;

    initial begin
        // Reset state
        do_reset();
        #1;
        check_eq("rst_gv", gv, 0);
        check_eq("rst_gi", gi, 0);
        check_eq("rst_mvalid", m_if.tvalid, 0);
        check_eq("rst_sready", s_if.tready, 0);
        check_eq("rst_mvalid_nl", m2_if.tvalid, 0);

        // Single source 2, three-beat frame
        ob = out_q.size();
        src_base[2] = 8'hA1; src_len[2] = 3; src_frames[2] = 1;
        #1;
        check_eq("s1_idle_rdy", s_if.tready, 0);
        check_eq("s1_idle_gv", gv, 0);
        step();
        check_eq("s1_gv", gv, 1);
        check_eq("s1_gi", gi, 2);
        check_eq("s1_rdy", s_if.tready, 4'b0100);
        check_eq("s1_mv0", m_if.tvalid, 0);
        step();
        check_eq("s1_mv1", m_if.tvalid, 1);
        check_eq("s1_d1", m_if.tdata, 8'hA1);
        check_eq("s1_id", m_if.tid, 2);
        check_eq("s1_dest", m_if.tdest, 8'h12);
        step();
        check_eq("s1_d2", m_if.tdata, 8'hA2);
        check_eq("s1_l2", m_if.tlast, 0);
        step();
        check_eq("s1_d3", m_if.tdata, 8'hA3);
        check_eq("s1_l3", m_if.tlast, 1);
        check_eq("s1_idle_gv2", gv, 0);
        check_eq("s1_idle_rdy2", s_if.tready, 0);
        step();
        check_eq("s1_drained", m_if.tvalid, 0);
        check_eq("s1_nbeats", out_q.size() - ob, 3);

        // Fairness: four sources, two 2-beat frames each
        do_reset();
        ob = out_q.size();
        og = grant_q.size();
        for (int i = 0; i < S; i++) begin
            src_base[i] = 8'(i * 16); src_len[i] = 2; src_frames[i] = 2;
        end
        for (int n = 0; n < 60 && (out_q.size() - ob) < 16; n++) step();
        check_eq("s2_nbeats", out_q.size() - ob, 16);
        check_eq("s2_ngrants", grant_q.size() - og, 8);
        for (int f = 0; f < 8 && og + f < grant_q.size(); f++)
            check_eq($sformatf("s2_grant%0d", f), grant_q[og + f], f % 4);
        for (int k = 0; k < 16 && ob + k < out_q.size(); k++) begin
            check_eq($sformatf("s2_data%0d", k), out_q[ob + k].data, ((k / 2) % 4) * 16 + k % 2);
            check_eq($sformatf("s2_id%0d", k), out_q[ob + k].id, (k / 2) % 4);
            check_eq($sformatf("s2_last%0d", k), out_q[ob + k].last, k % 2);
            if (k > 0)
                check_eq($sformatf("s2_gap%0d", k), out_q[ob + k].stamp - out_q[ob + k - 1].stamp,
                         (k % 2 == 1) ? 1 : 2);
        end

        // Backpressure: source 1, five beats, downstream ready 1,0,0 repeating
        do_reset();
        ob = out_q.size();
        src_base[1] = 8'h50; src_len[1] = 5; src_frames[1] = 1;
        for (int n = 0; n < 40 && (out_q.size() - ob) < 5; n++) begin
            m_rdy = (n % 3 == 0);
            #1;
            if (gv && m_if.tvalid[0]) check_eq($sformatf("s3_track%0d", n), s_if.tready[1], m_rdy);
            step();
        end
        m_rdy = 1'b1;
        step();
        step();
        check_eq("s3_nbeats", out_q.size() - ob, 5);
        for (int k = 0; k < 5 && ob + k < out_q.size(); k++) begin
            check_eq($sformatf("s3_data%0d", k), out_q[ob + k].data, 8'h50 + k);
            check_eq($sformatf("s3_last%0d", k), out_q[ob + k].last, (k == 4) ? 1 : 0);
        end

        // Mid-frame stall: source 0 drops valid while source 3 waits
        do_reset();
        ob = out_q.size();
        og = grant_q.size();
        src_base[0] = 8'h60; src_len[0] = 4; src_frames[0] = 1;
        src_base[3] = 8'h70; src_len[3] = 2; src_frames[3] = 1;
        step();
        check_eq("s4_gi_first", gi, 0);
        step();
        src_stall[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq($sformatf("s4_hold_gi%0d", n), gi, 0);
            check_eq($sformatf("s4_hold_gv%0d", n), gv, 1);
            check_eq($sformatf("s4_hold_rdy3_%0d", n), s_if.tready[3], 0);
        end
        src_stall[0] = 1'b0;
        for (int n = 0; n < 30 && (out_q.size() - ob) < 6; n++) step();
        check_eq("s4_nbeats", out_q.size() - ob, 6);
        check_eq("s4_ngrants", grant_q.size() - og, 2);
        if (grant_q.size() - og >= 2) begin
            check_eq("s4_grant0", grant_q[og], 0);
            check_eq("s4_grant1", grant_q[og + 1], 3);
        end
        for (int k = 0; k < 6 && ob + k < out_q.size(); k++)
            check_eq($sformatf("s4_data%0d", k), out_q[ob + k].data,
                     (k < 4) ? 8'h60 + k : 8'h70 + (k - 4));

        // LAST_ENABLE=0: every beat is its own frame
        do_reset();
        ob = out2_q.size();
        en2 = 1'b1;
        for (int n = 0; n < 30 && (out2_q.size() - ob) < 4; n++) step();
        en2 = 1'b0;
        check_eq("s5_nbeats", out2_q.size() - ob >= 4, 1);
        for (int k = 0; k < 4 && ob + k < out2_q.size(); k++) begin
            check_eq($sformatf("s5_data%0d", k), out2_q[ob + k].data, (k % 2 == 0) ? 8'hC0 : 8'hC1);
            check_eq($sformatf("s5_last%0d", k), out2_q[ob + k].last, 1);
            if (k > 0)
                check_eq($sformatf("s5_gap%0d", k), out2_q[ob + k].stamp - out2_q[ob + k - 1].stamp, 2);
        end

        // Reset during beat 2 of a 4-beat frame from source 2
        do_reset();
        src_base[2] = 8'h80; src_len[2] = 4; src_frames[2] = 1;
        step();
        step();
        step();
        check_eq("s6_pre_data", m_if.tdata, 8'h81);
        check_eq("s6_pre_gv", gv, 1);
        rst = 1'b1;
        for (int i = 0; i < S; i++) begin
            src_frames[i] = 0; src_beat[i] = 0;
        end
        step();
        check_eq("s6_mvalid", m_if.tvalid, 0);
        check_eq("s6_gv", gv, 0);
        check_eq("s6_rdy", s_if.tready, 0);
        check_eq("s6_gi", gi, 0);
        rst = 1'b0;
        src_base[1] = 8'h90; src_len[1] = 1; src_frames[1] = 1;
        src_base[3] = 8'hB0; src_len[3] = 1; src_frames[3] = 1;
        step();
        check_eq("s6_rearb_gv", gv, 1);
        check_eq("s6_rearb_gi", gi, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
